muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit in the execute stage. It consumes the operand pair rd1/rd2 that decode's operand-select logic produces, together with the ALU function and the word flag. For DIV/REM word forms those operands arrive already sign-extended, and for DIVU/REMU word forms already zero-extended. The unit iterates one bit per cycle, stalls the pipeline through busy, and returns a 64-bit result with a one-cycle done pulse.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  request present; held high by upstream until done
flush  in  1  abort current operation (branch/exception squash)
func  in  3  mdu_func_t: MUL, DIV, DIVU, REM, REMU
is_word  in  1  RV64 *W form; result sign-extended from bit 31
src1  in  XLEN  dividend / multiplicand (rd1)
src2  in  XLEN  divisor / multiplier (rd2)
busy  out  1  operation in flight; pipeline must stall
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  final result, held until next acceptance

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. On reset: state=IDLE, busy=0, done=0, result=0, count=0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - When valid_in=1 and flush=0, latch func, is_word and operands, clear count, go to BUSY.
  - The acceptance cycle is A.
- Operand preparation for signed DIV/REM:
  - Operate on |src1| and |src2|.
  - Record neg_q = sign1 XOR sign2 and neg_r = sign1.
- BUSY, multiply:
  - Shift-add; each cycle, if multiplier bit[count]=1, acc += multiplicand << count.
  - Result is the low XLEN bits.
- BUSY, divide:
  - Restoring division.
  - Each cycle rem = {rem, dividend msb}.
  - If rem >= divisor, then rem -= divisor and the quotient bit is 1.
  - count increments each cycle.
  - After count reaches XLEN-1, go to DONE.
- Short-circuit: divisor=0 or signed overflow (src1=0x8000_0000_0000_0000, src2=-1, 64-bit DIV/REM) goes straight from acceptance to DONE with no iterations.
- DONE:
  - done=1 for exactly one cycle, busy=0, then go to IDLE.
  - In IDLE a new request may be accepted on the next cycle.
- Latency:
  - Normal: done in cycle A+XLEN+1, i.e. A+65.
  - Short-circuit: done in cycle A+1.
- busy=1 in BUSY, and also combinationally in IDLE when valid_in=1, so the stall begins in cycle A.
- Result selection:
  - MUL: product[XLEN-1:0].
  - DIV/DIVU: quotient; negated if neg_q (signed only).
  - REM/REMU: remainder; negated if neg_r (signed only).
  - Divide by zero: quotient = all ones, remainder = src1.
  - Signed overflow: quotient = src1, remainder = 0.
  - is_word: result = sign-extend(result[31:0]).
  - Word overflow needs no special case, because the sign-extended operands yield the correct 0xFFFFFFFF80000000.
- flush:
  - In BUSY or DONE, go to IDLE next cycle with done=0.
  - result is not updated.
  - flush in IDLE suppresses acceptance.
- reset mid-operation aborts identically to flush and also clears result.
- valid_in dropping while in BUSY is ignored; only flush aborts.

Decomposition:
- Shared pipes package holds:
  - mdu_func_t enum (3 bits): MUL=0, DIV=1, DIVU=2, REM=3, REMU=4.
  - mdu_state_t enum.
  - XLEN-derived word_t (already present).
- One natural sub-module: div_iter, the restoring-division datapath.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, last.
- The top module keeps the FSM, sign handling, multiply and result mux.

Test Plan:
- DIVU src1=100, src2=7 accepted at cycle 0 -> busy cycles 0..64, done at cycle 65, result=14; REMU same operands -> result=2.
- DIV src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> result=0xFFFF_FFFF_FFFF_FFFD (-3); REM same -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU src2=0, src1=0x1234 -> done at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF; REMU -> 0x1234.
- DIV src1=0x8000_0000_0000_0000, src2=-1 -> done at cycle 1, result=0x8000_0000_0000_0000; REM -> 0.
- MUL is_word=1, src1=0x7FFF_FFFF, src2=2 -> result=0xFFFF_FFFF_FFFF_FFFE at cycle 65.
- DIVU started, flush at cycle 30 -> IDLE at cycle 31, no done pulse, result unchanged. A new DIVU 9/3 accepted at cycle 31 -> done at cycle 96 with result=3.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared types for the multi-cycle multiply/divide unit:
//               operation encoding, FSM state encoding and the word type.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int unsigned C_XLEN = 64;

    typedef logic [C_XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        MUL  = 3'd0,
        DIV  = 3'd1,
        DIVU = 3'd2,
        REM  = 3'd3,
        REMU = 3'd4
    } mdu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_div_iter
// Description : Restoring-division datapath, one quotient bit per cycle.
//               i_start loads the (unsigned) operands and clears the step
//               counter; each i_en cycle performs one shift/compare/subtract.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_start             - load operands, clear counter
//               i_en                - perform one iteration
//               i_dividend/divisor  - unsigned operands
//               o_quotient/remainder- running (final after XLEN steps) values
//               o_last              - current step is the final one
//               o_count             - current step index
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit_div_iter #(
    parameter int XLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_en,
    input  logic [XLEN-1:0]          i_dividend,
    input  logic [XLEN-1:0]          i_divisor,
    output logic [XLEN-1:0]          o_quotient,
    output logic [XLEN-1:0]          o_remainder,
    output logic                     o_last,
    output logic [$clog2(XLEN)-1:0]  o_count
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;     // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0] r_divisor;
    logic [CW-1:0]   r_count;

    logic [XLEN:0]   w_shift;    // one extra bit: shifted remainder can reach 2*divisor-1
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    always_comb begin
        w_shift = {r_rem, r_quot[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_divisor});
        // True difference is below 2^XLEN whenever it is used, so modulo arithmetic is exact.
        w_diff  = w_shift[XLEN-1:0] - r_divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_count   <= '0;
        end else if (i_en) begin
            r_rem     <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_quot    <= {r_quot[XLEN-2:0], w_ge};
            r_count   <= r_count + 1'b1;
        end
    end

    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;
    assign o_last      = (r_count == CW'(XLEN-1));
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle; divide-by-zero and
//               signed overflow complete one cycle after acceptance.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               valid_in, flush    - request present / abort
//               func, is_word      - operation, RV64 *W form
//               src1, src2         - operands
//               busy, done, result - stall, one-cycle completion, result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = C_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [2:0]      func,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_t      r_state, w_state_next;
    mdu_func_t       r_func;
    logic            r_word, r_neg_q, r_neg_r, r_dz, r_ovf;
    logic [XLEN-1:0] r_a, r_b, r_acc, r_result;

    mdu_func_t       w_func;
    logic            w_start, w_is_div, w_signed, w_dz_in, w_ovf_in, w_short;
    logic            w_done, w_in_busy, w_last;
    logic [XLEN-1:0] w_abs1, w_abs2, w_quot, w_rem, w_raw, w_final;
    logic [CW-1:0]   w_count;

    // ---------------- acceptance decode ----------------
    always_comb begin
        w_func    = mdu_func_t'(func);
        w_start   = (r_state == IDLE) && valid_in && !flush;
        w_is_div  = (w_func == DIV) || (w_func == DIVU) || (w_func == REM) || (w_func == REMU);
        w_signed  = (w_func == DIV) || (w_func == REM);
        w_dz_in   = w_is_div && (src2 == '0);
        // Word-form overflow resolves naturally from the sign-extended operands.
        w_ovf_in  = w_signed && !is_word && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
        w_short   = w_dz_in || w_ovf_in;
        w_abs1    = (w_signed && src1[XLEN-1]) ? -src1 : src1;
        w_abs2    = (w_signed && src2[XLEN-1]) ? -src2 : src2;
        w_in_busy = (r_state == BUSY);
        w_done    = (r_state == DONE) && !flush;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = w_short ? DONE : BUSY;
            BUSY:    if (flush) w_state_next = IDLE;
                     else if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (r_state == BUSY) || ((r_state == IDLE) && valid_in);
        done   = w_done;
        // The final value is presented in the done cycle and captured for holding.
        result = w_done ? w_final : r_result;
    end

    // ---------------- divide datapath ----------------
    muldiv_unit_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk         (clk),
        .rst         (reset),
        .i_start     (w_start),
        .i_en        (w_in_busy),
        .i_dividend  (w_abs1),
        .i_divisor   (w_abs2),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_last      (w_last),
        .o_count     (w_count)
    );

    // ---------------- operand latch, multiply, result hold ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_func   <= MUL;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_start) begin
                r_func  <= w_func;
                r_word  <= is_word;
                r_neg_q <= w_signed && (src1[XLEN-1] ^ src2[XLEN-1]);
                r_neg_r <= w_signed && src1[XLEN-1];
                r_dz    <= w_dz_in;
                r_ovf   <= w_ovf_in;
                r_a     <= src1;
                r_b     <= src2;
                r_acc   <= '0;
            end else if (w_in_busy && r_b[w_count]) begin
                r_acc   <= r_acc + (r_a << w_count);
            end
            if (w_done) r_result <= w_final;
        end
    end

    // ---------------- result select ----------------
    always_comb begin
        w_raw = '0;
        case (r_func)
            MUL:       w_raw = r_acc;
            DIV, DIVU: w_raw = r_dz  ? '1  :
                               r_ovf ? r_a : (r_neg_q ? -w_quot : w_quot);
            REM, REMU: w_raw = r_dz  ? r_a :
                               r_ovf ? '0  : (r_neg_r ? -w_rem : w_rem);
            default:   w_raw = '0;
        endcase
        w_final = r_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit. Stimulus pushes expected
//               result and completion cycle; a monitor checks every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func = 3'd0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        busy, done;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [63:0] last_res = '0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .flush    (flush),
        .func     (func),
        .is_word  (is_word),
        .src1     (src1),
        .src2     (src2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done with result %h, expected no done", result);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.name, "_result"}, result, m_e.res);
                chk({m_e.name, "_cycle"}, 64'(cyc), 64'(m_e.cyc));
                chk({m_e.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
            end
        end
    end

    // Drive a request in the current (negedge) slot; optionally queue its expectation.
    task automatic start_op(input string nm, input mdu_func_t f, input logic w,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp, input int lat, input bit push);
        func     = f;
        is_word  = w;
        src1     = a;
        src2     = b;
        valid_in = 1'b1;
        if (push) begin
            sb.push_back('{exp, cyc + lat, nm});
            last_res = exp;
        end
        #1;
        chk({nm, "_busy_at_accept"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input string nm, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (drop && i == 4) valid_in = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done in 150 cycles, expected done", nm);
            sb.delete();
        end
        valid_in = 1'b0;
    endtask

    task automatic run_op(input string nm, input mdu_func_t f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input bit drop);
        @(negedge clk);
        start_op(nm, f, w, a, b, exp, lat, 1'b1);
        wait_done(nm, drop);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {63'd0, busy}, 64'd0);
        chk("reset_done",   {63'd0, done}, 64'd0);
        chk("reset_result", result,        64'd0);
        reset = 1'b0;

        run_op("divu_100_7",  DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0);
        run_op("remu_100_7",  REMU, 1'b0, 64'd100, 64'd7, 64'd2,  65, 1'b0);
        run_op("div_m7_2",    DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op("rem_m7_2",    REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("divu_by0",    DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op("remu_by0",    REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 1'b0);
        run_op("div_ovf",     DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1'b0);
        run_op("rem_ovf",     REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
        run_op("mulw",        MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("mul_drop",    MUL,  1'b0, 64'h1_0000_0003, 64'd5, 64'h5_0000_000F, 65, 1'b1);
        run_op("divw_ovf",    DIV,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 65, 1'b0);
        run_op("div_7_m2",    DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op("rem_7_m2",    REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 1'b0);
        run_op("div_m5_by0",  DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op("rem_m5_by0",  REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 1'b0);

        // Flush in BUSY: no done, result held, immediate re-acceptance.
        @(negedge clk);
        a = cyc;
        start_op("divu_flushed", DIVU, 1'b0, 64'd1000, 64'd7, 64'd0, 0, 1'b0);
        repeat (30) @(negedge clk);
        chk("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle", 64'(cyc), 64'(a + 31));
        chk("flush_no_done", {63'd0, done}, 64'd0);
        chk("flush_result_held", result, last_res);
        flush = 1'b0;
        start_op("divu_9_3", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 1'b1);
        wait_done("divu_9_3", 1'b0);

        // Reset mid-operation aborts and clears result.
        @(negedge clk);
        start_op("divu_reset", DIVU, 1'b0, 64'd50, 64'd5, 64'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("midreset_result", result, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        run_op("divu_after_reset", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
